// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: one valid/ready bus access at a time, with lane steering and load extension.
// Optional build macro LSU_MISALIGN_CHECK_EN turns misaligned accesses into error responses.
module ysyx_25030093_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        illegal;
  logic        fault;
  logic [1:0]  eff_off;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);

  // funct3[1:0] encodes the size (byte/half/word); 2'b11 is never a legal size.
  always_comb begin
    if (req_wen)
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);
    eff_off = req_addr[1:0];
    if (req_funct3[1:0] == 2'b01)
      eff_off[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10)
      eff_off = 2'b00;
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign fault = illegal || misaligned;
`else
  assign fault = illegal;
`endif

  always_comb begin
    st_mask = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << eff_off;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << eff_off;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wen_q         <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      mem_req_valid <= 1'b0;
      mem_wen       <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_wmask     <= 4'd0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'd0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q    <= req_wen;
            funct3_q <= req_funct3;
            off_q    <= eff_off;
            if (fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_wen       <= req_wen;
              mem_addr      <= {req_addr[31:2], 2'b00};
              mem_wdata     <= req_wen ? st_data : 32'd0;
              mem_wmask     <= req_wen ? st_mask : 4'd0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= wen_q ? 32'd0 : load_data;
          end
        end
        RESP: begin
          // Return to IDLE before taking the next request.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Randomized self-checking bench for ysyx_25030093_lsu against a byte-level access model.
// Build with LSU_MISALIGN_CHECK_EN defined to match an RTL build with that option.
module tb_ysyx_25030093_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int bus_hs = 0;
  int rsp_hs = 0;

  logic        exp_active = 1'b0;
  logic        exp_fault = 1'b0;
  logic        exp_wen = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [3:0]  exp_wmask = 4'd0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  ysyx_25030093_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level model of one access: which bytes are touched, and what value comes back.
  function automatic void model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic fault, output logic [31:0] baddr,
                                output logic [31:0] bwdata, output logic [3:0] bmask,
                                output logic [31:0] rdat);
    int nbytes;
    int off;
    logic legal;
    logic misal;
    logic [31:0] val;
    nbytes = 1 << int'(f3[1:0]);
    off    = int'(addr % 4);
    legal  = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal  = (off % nbytes) != 0;
`ifdef LSU_MISALIGN_CHECK_EN
    fault = !legal || misal;
`else
    fault = !legal;
    if (legal) off = off - (off % nbytes);
`endif
    baddr  = addr & 32'hFFFF_FFFC;
    bmask  = 4'd0;
    bwdata = 32'd0;
    if (wen) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nbytes) bmask[b] = 1'b1;
        bwdata[8*b +: 8] = wdata[8*(b % nbytes) +: 8];
      end
    end
    val = rdata >> (8 * off);
    if (nbytes < 4) begin
      val = val & ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!f3[2] && val >= (32'd1 << (8 * nbytes - 1)))
        val = val - (32'd1 << (8 * nbytes));
    end
    rdat = (wen || fault) ? 32'd0 : val;
  endfunction

  // Compare process: whenever the DUT presents a bus request or a response, it must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid) begin
        chk("bus_req_allowed", {63'd0, exp_active && !exp_fault}, 64'd1);
        chk("bus_addr", mem_addr, exp_addr);
        chk("bus_ctl", {mem_wen, mem_wmask, mem_wdata}, {exp_wen, exp_wmask, exp_wdata});
        if (mem_req_ready) bus_hs++;
      end
      if (rsp_valid) begin
        chk("rsp_allowed", {63'd0, exp_active}, 64'd1);
        chk("rsp_payload", {rsp_err, rsp_data}, {exp_err, exp_rdata});
        if (rsp_ready) rsp_hs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int req_stall, input int rsp_delay, input int wbu_stall,
                        input bit overlap,
                        output logic [31:0] got_data, output logic got_err,
                        output logic [31:0] got_addr, output logic [31:0] got_wdata,
                        output logic [3:0] got_mask);
    int bus0;
    int rsp0;
    model(wen, f3, addr, wdata, rdata, exp_fault, exp_addr, exp_wdata, exp_wmask, exp_rdata);
    exp_wen    = wen;
    exp_err    = exp_fault;
    exp_active = 1'b1;
    bus0 = bus_hs;
    rsp0 = rsp_hs;
    got_addr  = 32'd0;
    got_wdata = 32'd0;
    got_mask  = 4'd0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_wen = 1'($urandom_range(1)); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("req_ready_busy", req_ready, 0);
    if (!exp_fault) begin
      chk("mem_req_valid_c1", mem_req_valid, 1);
      got_addr = mem_addr; got_wdata = mem_wdata; got_mask = mem_wmask;
      for (int i = 0; i < req_stall; i++) begin
        mem_rsp_valid = 1'($urandom_range(1));
        mem_rdata = $urandom;
        step();
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("mem_req_drop", mem_req_valid, 0);
      for (int i = 0; i < rsp_delay; i++) begin
        chk("rsp_early", rsp_valid, 0);
        step();
      end
      mem_rsp_valid = 1'b1;
      mem_rdata = rdata;
      step();
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
    end
    chk("rsp_valid_latency", rsp_valid, 1);
    got_data = rsp_data;
    got_err  = rsp_err;
    for (int i = 0; i < wbu_stall; i++) begin
      mem_rsp_valid = 1'($urandom_range(1));
      step();
    end
    mem_rsp_valid = 1'b0;
    rsp_ready = 1'b1;
    if (overlap) begin
      req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0100;
    end
    chk("req_ready_resp", req_ready, 0);
    step();
    rsp_ready  = 1'b0;
    req_valid  = 1'b0;
    exp_active = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    step();
    chk("bus_count", bus_hs - bus0, exp_fault ? 1'b0 : 1'b1);
    chk("rsp_count", rsp_hs - rsp0, 1);
    $display("txn wen=%0d f3=%0d addr=%08h wdata=%08h -> rsp_data=%08h err=%0d",
             wen, f3, addr, wdata, got_data, got_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  m;
    logic        e;
    logic [2:0]  legal_ld [5];
    logic        w;
    logic [2:0]  f;
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    #12;
    chk("reset_ctl", {mem_req_valid, mem_wen, rsp_valid, rsp_err, mem_wmask}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_data", {mem_wdata, rsp_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("reset_req_ready", req_ready, 1);

    do_txn(1'b0, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, d, e, a, wd, m);
    chk("lw_addr", a, 32'h8000_0004);
    chk("lw_data", {e, d}, {1'b0, 32'hDEAD_BEEF});
    do_txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h8011_2233, 0, 1, 0, 0, d, e, a, wd, m);
    chk("lb_data", d, 32'hFFFF_FF80);
    do_txn(1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h8011_2233, 0, 0, 1, 1, d, e, a, wd, m);
    chk("lbu_data", d, 32'h0000_0080);
    do_txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h8011_2233, 1, 0, 0, 0, d, e, a, wd, m);
    chk("lhu_data", d, 32'h0000_8011);
    do_txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 0, 0, d, e, a, wd, m);
    chk("sh_mask", m, 4'b1100);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_rsp", {e, d}, 33'd0);
    do_txn(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'd0, 5, 2, 3, 1, d, e, a, wd, m);
    chk("sw_stall_mask", {m, wd}, {4'b1111, 32'hCAFE_F00D});
    do_txn(1'b0, 3'b011, 32'h8000_0010, 32'd0, 32'h1111_1111, 0, 0, 2, 0, d, e, a, wd, m);
    chk("illegal_ld", {e, d}, {1'b1, 32'd0});
    do_txn(1'b1, 3'b100, 32'h8000_0010, 32'h7777_7777, 32'd0, 0, 0, 0, 0, d, e, a, wd, m);
    chk("illegal_st", e, 1);
    do_txn(1'b0, 3'b010, 32'h8000_0001, 32'd0, 32'h1122_3344, 0, 0, 0, 0, d, e, a, wd, m);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misalign_err", {e, d}, {1'b1, 32'd0});
`else
    chk("misalign_addr", a, 32'h8000_0000);
    chk("misalign_data", {e, d}, {1'b0, 32'h1122_3344});
`endif

    // Reset while waiting for a read response, then a stray response in IDLE.
    model(1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'd0, exp_fault, exp_addr, exp_wdata, exp_wmask, exp_rdata);
    exp_wen = 1'b0; exp_err = 1'b0; exp_active = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    exp_active = 1'b0;
    #2;
    chk("midrst_ctl", {mem_req_valid, mem_wen, rsp_valid, rsp_err, mem_wmask}, 0);
    chk("midrst_data", {mem_addr, rsp_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_dropped", rsp_valid, 0);
    chk("stray_req_ready", req_ready, 1);
    step();
    do_txn(1'b0, 3'b001, 32'h8000_0022, 32'd0, 32'hF00D_1234, 0, 0, 0, 0, d, e, a, wd, m);
    chk("post_rst_lh", d, 32'hFFFF_F00D);

    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) f = 3'($urandom);
      else if (w) f = 3'($urandom_range(2));
      else f = legal_ld[$urandom_range(4)];
      do_txn(w, f, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
             $urandom_range(3), $urandom_range(3), $urandom_range(3), bit'($urandom_range(1)),
             d, e, a, wd, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
